cache_miss_sequencer: RTL and testbench

Sequences a single cache miss for the 4-way set-associative cache: on a miss it writes back the dirty victim line to memory, refills the victim way from memory beat by beat, then rewrites the victim's tag. It sits between the hit/lookup logic, which supplies the miss address and the victim way, and the data/tag arrays and the memory interface. It handles one miss at a time.

---
 rtl/cache_miss_sequencer.sv | 179 +++++++++++++++++
 tb/tb_cache_miss_sequencer.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_sequencer.sv
// Single-miss sequencer for a set-associative cache: optional dirty-victim writeback,
// beat-by-beat refill of the victim way, then the victim's tag is rewritten.
module cache_miss_sequencer #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned LINE_SIZE_BYTES = 64,
  parameter int unsigned WAYS            = 4,
  parameter int unsigned TAG_BITS        = 18,
  parameter int unsigned INDEX_WIDTH     = 8,
  parameter int unsigned OFFSET_WIDTH    = 6,
  localparam int unsigned BEATS          = LINE_SIZE_BYTES * 8 / DATA_WIDTH,
  localparam int unsigned BEAT_W         = $clog2(BEATS),
  localparam int unsigned WAY_W          = $clog2(WAYS),
  localparam int unsigned ADDRESS_WIDTH  = TAG_BITS + INDEX_WIDTH + OFFSET_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_miss_valid,
  output logic                     o_miss_ready,
  input  logic [ADDRESS_WIDTH-1:0] i_miss_address,
  input  logic [WAY_W-1:0]         i_victim_way,
  input  logic                     i_victim_dirty,
  input  logic [TAG_BITS-1:0]      i_victim_tag,
  output logic                     o_arr_rd_en,
  output logic                     o_arr_wr_en,
  output logic [WAY_W-1:0]         o_arr_way,
  output logic [INDEX_WIDTH-1:0]   o_arr_index,
  output logic [BEAT_W-1:0]        o_arr_beat,
  input  logic [DATA_WIDTH-1:0]    i_arr_rd_data,
  output logic [DATA_WIDTH-1:0]    o_arr_wr_data,
  output logic                     o_tag_wr_en,
  output logic                     o_tag_wr_valid,
  output logic [TAG_BITS-1:0]      o_tag_wr_tag,
  output logic                     o_mem_req_valid,
  input  logic                     i_mem_req_ready,
  output logic                     o_mem_req_write,
  output logic [ADDRESS_WIDTH-1:0] o_mem_req_addr,
  output logic                     o_mem_wdata_valid,
  input  logic                     i_mem_wdata_ready,
  output logic [DATA_WIDTH-1:0]    o_mem_wdata,
  input  logic                     i_mem_rdata_valid,
  input  logic [DATA_WIDTH-1:0]    i_mem_rdata,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    StIdle, StWbReq, StWbRd, StWbSend, StFillReq, StFillData, StTagUpd, StDone
  } state_e;

  state_e                   state_q;
  logic [INDEX_WIDTH-1:0]   index_q;
  logic [TAG_BITS-1:0]      miss_tag_q;
  logic [TAG_BITS-1:0]      victim_tag_q;
  logic [WAY_W-1:0]         way_q;
  logic [BEAT_W-1:0]        beat_q;
  logic [DATA_WIDTH-1:0]    hold_q;
  // Marks the first cycle of WB_SEND (data capture) and of FILL_REQ (tag invalidate).
  logic                     first_q;

  logic unused_offset;
  assign unused_offset = ^i_miss_address[OFFSET_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      index_q      <= '0;
      miss_tag_q   <= '0;
      victim_tag_q <= '0;
      way_q        <= '0;
      beat_q       <= '0;
      hold_q       <= '0;
      first_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_miss_valid) begin
            index_q      <= i_miss_address[OFFSET_WIDTH +: INDEX_WIDTH];
            miss_tag_q   <= i_miss_address[ADDRESS_WIDTH-1 -: TAG_BITS];
            victim_tag_q <= i_victim_tag;
            way_q        <= i_victim_way;
            beat_q       <= '0;
            first_q      <= 1'b1;
            state_q      <= i_victim_dirty ? StWbReq : StFillReq;
          end
        end
        StWbReq: begin
          if (i_mem_req_ready) state_q <= StWbRd;
        end
        StWbRd: begin
          first_q <= 1'b1;
          state_q <= StWbSend;
        end
        StWbSend: begin
          first_q <= 1'b0;
          if (first_q) hold_q <= i_arr_rd_data;
          if (i_mem_wdata_ready) begin
            if (beat_q == LastBeat) begin
              beat_q  <= '0;
              first_q <= 1'b1;
              state_q <= StFillReq;
            end else begin
              beat_q  <= beat_q + 1'b1;
              state_q <= StWbRd;
            end
          end
        end
        StFillReq: begin
          first_q <= 1'b0;
          if (i_mem_req_ready) state_q <= StFillData;
        end
        StFillData: begin
          if (i_mem_rdata_valid) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == LastBeat) state_q <= StTagUpd;
          end
        end
        StTagUpd: state_q <= StDone;
        StDone:   state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    o_miss_ready      = (state_q == StIdle);
    o_busy            = (state_q != StIdle);
    o_done            = (state_q == StDone);
    o_arr_way         = o_busy ? way_q : '0;
    o_arr_index       = o_busy ? index_q : '0;
    o_arr_beat        = '0;
    o_arr_rd_en       = 1'b0;
    o_arr_wr_en       = 1'b0;
    o_arr_wr_data     = '0;
    o_tag_wr_en       = 1'b0;
    o_tag_wr_valid    = 1'b0;
    o_tag_wr_tag      = '0;
    o_mem_req_valid   = 1'b0;
    o_mem_req_write   = 1'b0;
    o_mem_req_addr    = '0;
    o_mem_wdata_valid = 1'b0;
    o_mem_wdata       = '0;
    unique case (state_q)
      StWbReq: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_write = 1'b1;
        o_mem_req_addr  = {victim_tag_q, index_q, {OFFSET_WIDTH{1'b0}}};
      end
      StWbRd: begin
        o_arr_rd_en = 1'b1;
        o_arr_beat  = beat_q;
      end
      StWbSend: begin
        // Array data is only valid in the first cycle; afterwards replay the held copy.
        o_mem_wdata_valid = 1'b1;
        o_mem_wdata       = first_q ? i_arr_rd_data : hold_q;
      end
      StFillReq: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_addr  = {miss_tag_q, index_q, {OFFSET_WIDTH{1'b0}}};
        o_tag_wr_en     = first_q;
        o_tag_wr_tag    = first_q ? miss_tag_q : '0;
      end
      StFillData: begin
        o_arr_wr_en   = i_mem_rdata_valid;
        o_arr_wr_data = i_mem_rdata;
        o_arr_beat    = beat_q;
      end
      StTagUpd: begin
        o_tag_wr_en    = 1'b1;
        o_tag_wr_valid = 1'b1;
        o_tag_wr_tag   = miss_tag_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// Scoreboard bench for cache_miss_sequencer: stimulus pushes expected events into queues,
// a negedge monitor pops and compares them; a small reactive model plays array and memory.
module tb_cache_miss_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss_valid;
  logic        o_miss_ready;
  logic [31:0] i_miss_address;
  logic [1:0]  i_victim_way;
  logic        i_victim_dirty;
  logic [17:0] i_victim_tag;
  logic        o_arr_rd_en, o_arr_wr_en;
  logic [1:0]  o_arr_way;
  logic [7:0]  o_arr_index;
  logic [3:0]  o_arr_beat;
  logic [31:0] i_arr_rd_data, o_arr_wr_data;
  logic        o_tag_wr_en, o_tag_wr_valid;
  logic [17:0] o_tag_wr_tag;
  logic        o_mem_req_valid, i_mem_req_ready, o_mem_req_write;
  logic [31:0] o_mem_req_addr;
  logic        o_mem_wdata_valid, i_mem_wdata_ready;
  logic [31:0] o_mem_wdata;
  logic        i_mem_rdata_valid;
  logic [31:0] i_mem_rdata;
  logic        o_busy, o_done;

  cache_miss_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .i_miss_valid     (i_miss_valid),
    .o_miss_ready     (o_miss_ready),
    .i_miss_address   (i_miss_address),
    .i_victim_way     (i_victim_way),
    .i_victim_dirty   (i_victim_dirty),
    .i_victim_tag     (i_victim_tag),
    .o_arr_rd_en      (o_arr_rd_en),
    .o_arr_wr_en      (o_arr_wr_en),
    .o_arr_way        (o_arr_way),
    .o_arr_index      (o_arr_index),
    .o_arr_beat       (o_arr_beat),
    .i_arr_rd_data    (i_arr_rd_data),
    .o_arr_wr_data    (o_arr_wr_data),
    .o_tag_wr_en      (o_tag_wr_en),
    .o_tag_wr_valid   (o_tag_wr_valid),
    .o_tag_wr_tag     (o_tag_wr_tag),
    .o_mem_req_valid  (o_mem_req_valid),
    .i_mem_req_ready  (i_mem_req_ready),
    .o_mem_req_write  (o_mem_req_write),
    .o_mem_req_addr   (o_mem_req_addr),
    .o_mem_wdata_valid(o_mem_wdata_valid),
    .i_mem_wdata_ready(i_mem_wdata_ready),
    .o_mem_wdata      (o_mem_wdata),
    .i_mem_rdata_valid(i_mem_rdata_valid),
    .i_mem_rdata      (i_mem_rdata),
    .o_busy           (o_busy),
    .o_done           (o_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Expected-event queues
  logic [45:0] arr_q[$];   // {way, index, beat, data}
  logic [32:0] req_q[$];   // {write, addr}
  logic [31:0] wd_q[$];
  logic [28:0] tag_q[$];   // {valid, way, index, tag}
  int          lat_q[$];
  int          acc_q[$];
  logic [31:0] base_q[$];

  // Memory model controls, shared with the monitor
  int req_stall_left = 0;
  int wd_stall_beat  = -1;
  int wd_stall_left  = 0;
  int wb_beat        = 0;
  int fill_req_cnt   = 0;
  bit gap_mode       = 1'b0;
  bit spurious_en    = 1'b0;
  int last_done_cyc  = 0;

  initial forever @(posedge clk) cyc++;

  function automatic logic [31:0] arr_word(input logic [1:0] w, input logic [7:0] idx,
                                           input logic [3:0] b);
    return {4'hC, 2'b00, w, 8'h5A, idx, 4'h0, b};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event expected none", name);
  endtask

  task automatic expect_miss(input logic [31:0] addr, input logic [1:0] way, input logic dirty,
                             input logic [17:0] vtag, input logic [31:0] base, input int lat);
    logic [7:0]  idx;
    logic [17:0] tag;
    idx = addr[13:6];
    tag = addr[31:14];
    if (dirty) begin
      req_q.push_back({1'b1, vtag, idx, 6'b0});
      for (int n = 0; n < 16; n++) wd_q.push_back(arr_word(way, idx, 4'(n)));
    end
    req_q.push_back({1'b0, tag, idx, 6'b0});
    tag_q.push_back({1'b0, way, idx, 18'h0});
    for (int n = 0; n < 16; n++) arr_q.push_back({way, idx, 4'(n), base + 32'(n)});
    tag_q.push_back({1'b1, way, idx, tag});
    lat_q.push_back(lat);
    base_q.push_back(base);
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic [1:0] way, input logic dirty,
                           input logic [17:0] vtag);
    i_miss_valid   = 1'b1;
    i_miss_address = addr;
    i_victim_way   = way;
    i_victim_dirty = dirty;
    i_victim_tag   = vtag;
  endtask

  task automatic wait_accept();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_miss_ready && n < 200);
    if (!o_miss_ready) fail_event("timeout_accept");
    @(posedge clk);
    #1;
  endtask

  // Issue one miss, then scramble the request inputs so any late sampling shows up.
  task automatic issue(input logic [31:0] addr, input logic [1:0] way, input logic dirty,
                       input logic [17:0] vtag, input logic [31:0] base, input int lat);
    expect_miss(addr, way, dirty, vtag, base, lat);
    drive_req(addr, way, dirty, vtag);
    wait_accept();
    i_miss_valid   = 1'b0;
    i_miss_address = ~addr;
    i_victim_way   = ~way;
    i_victim_dirty = ~dirty;
    i_victim_tag   = ~vtag;
  endtask

  task automatic wait_done(input bit resync);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_done && n < 300);
    if (!o_done) fail_event("timeout_done");
    if (resync) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    logic [45:0] ea;
    logic [32:0] er;
    logic [28:0] et;
    logic        wd_stalled_prev;
    logic [31:0] wd_prev;
    wd_stalled_prev = 1'b0;
    wd_prev         = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (o_miss_ready && i_miss_valid) acc_q.push_back(cyc);
        if (o_arr_wr_en) begin
          if (arr_q.size() == 0) fail_event("unexpected_arr_wr");
          else begin
            ea = arr_q.pop_front();
            check("arr_wr", {o_arr_way, o_arr_index, o_arr_beat, o_arr_wr_data}, ea);
          end
        end
        if (o_mem_req_valid && i_mem_req_ready) begin
          if (req_q.size() == 0) fail_event("unexpected_mem_req");
          else begin
            er = req_q.pop_front();
            check("mem_req", {o_mem_req_write, o_mem_req_addr}, er);
          end
          if (o_mem_req_write) wb_beat = 0;
          else fill_req_cnt++;
        end
        if (o_mem_wdata_valid && wd_stalled_prev) check("wdata_stable", o_mem_wdata, wd_prev);
        wd_stalled_prev = o_mem_wdata_valid && !i_mem_wdata_ready;
        wd_prev         = o_mem_wdata;
        if (o_mem_wdata_valid && i_mem_wdata_ready) begin
          if (wd_q.size() == 0) fail_event("unexpected_wdata");
          else check("wdata", o_mem_wdata, wd_q.pop_front());
          wb_beat++;
        end
        if (o_tag_wr_en) begin
          if (tag_q.size() == 0) fail_event("unexpected_tag_wr");
          else begin
            et = tag_q.pop_front();
            if (!et[28]) begin
              check("tag_inval", {o_tag_wr_valid, o_arr_way, o_arr_index}, et[28:18]);
              check("inval_on_fill_req", o_mem_req_valid && !o_mem_req_write, 1);
            end else begin
              check("tag_write", {o_tag_wr_valid, o_arr_way, o_arr_index, o_tag_wr_tag}, et);
            end
          end
        end
        if (o_done) begin
          last_done_cyc = cyc;
          if (lat_q.size() == 0 || acc_q.size() == 0) fail_event("unexpected_done");
          else check("done_latency", cyc - acc_q.pop_front(), lat_q.pop_front());
        end
      end
    end
  end

  // Array read port and memory model
  initial begin : mem_model
    logic        rd_pend;
    logic [1:0]  rd_way;
    logic [7:0]  rd_idx;
    logic [3:0]  rd_beat;
    bit          fill_active;
    bit          fill_phase;
    int          fill_n;
    int          fill_started;
    logic [31:0] fill_base;
    fill_active = 1'b0;
    fill_phase  = 1'b0;
    fill_n      = 0;
    fill_started = 0;
    fill_base   = '0;
    i_mem_req_ready   = 1'b1;
    i_mem_wdata_ready = 1'b1;
    i_mem_rdata_valid = 1'b0;
    i_mem_rdata       = '0;
    i_arr_rd_data     = 32'hDEAD_0000;
    forever begin
      @(negedge clk);
      rd_pend = o_arr_rd_en;
      rd_way  = o_arr_way;
      rd_idx  = o_arr_index;
      rd_beat = o_arr_beat;
      @(posedge clk);
      #1;
      i_arr_rd_data = rd_pend ? arr_word(rd_way, rd_idx, rd_beat) : (32'hDEAD_0000 ^ 32'(cyc));
      if (!rst) begin
        fill_active  = 1'b0;
        fill_started = fill_req_cnt;
      end
      if (o_mem_req_valid && req_stall_left > 0) begin
        i_mem_req_ready = 1'b0;
        req_stall_left--;
      end else i_mem_req_ready = 1'b1;
      if (o_mem_wdata_valid && wb_beat == wd_stall_beat && wd_stall_left > 0) begin
        i_mem_wdata_ready = 1'b0;
        wd_stall_left--;
      end else i_mem_wdata_ready = 1'b1;
      if (rst && !fill_active && fill_req_cnt != fill_started) begin
        fill_active = 1'b1;
        fill_started++;
        fill_n      = 0;
        fill_phase  = 1'b0;
        fill_base   = (base_q.size() != 0) ? base_q.pop_front() : 32'hBAD0_0001;
      end
      if (fill_active) begin
        if (gap_mode && fill_phase) begin
          i_mem_rdata_valid = 1'b0;
          i_mem_rdata       = 32'hBAD0_0002;
        end else begin
          i_mem_rdata_valid = 1'b1;
          i_mem_rdata       = fill_base + 32'(fill_n);
          fill_n++;
          if (fill_n == 16) fill_active = 1'b0;
        end
        fill_phase = ~fill_phase;
      end else begin
        i_mem_rdata_valid = spurious_en;
        i_mem_rdata       = 32'hBAD0_0003;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    rst            = 1'b0;
    i_miss_valid   = 1'b0;
    i_miss_address = '0;
    i_victim_way   = '0;
    i_victim_dirty = 1'b0;
    i_victim_tag   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_ready", o_miss_ready, 1);
    check("reset_zero", |{o_arr_rd_en, o_arr_wr_en, o_arr_way, o_arr_index, o_arr_beat,
                          o_arr_wr_data, o_tag_wr_en, o_tag_wr_valid, o_tag_wr_tag,
                          o_mem_req_valid, o_mem_req_write, o_mem_req_addr,
                          o_mem_wdata_valid, o_mem_wdata, o_busy, o_done}, 0);

    // Clean miss: index 0x59, tag 0x048D1
    issue(32'h1234_5678, 2'd2, 1'b0, 18'h0, 32'hA0, 19);
    wait_done(1'b1);

    // Dirty miss, all-ones victim tag
    issue(32'h0ABC_D040, 2'd1, 1'b1, 18'h3FFFF, 32'h100, 52);
    wait_done(1'b1);

    // Backpressure: request ready low 2 cycles, writeback beat 5 stalled 3 cycles
    req_stall_left = 2;
    wd_stall_beat  = 5;
    wd_stall_left  = 3;
    issue(32'hF00D_1FC0, 2'd3, 1'b1, 18'h15A5A, 32'h200, 57);
    wait_done(1'b1);
    check("req_stall_used", req_stall_left, 0);
    check("wd_stall_used", wd_stall_left, 0);
    wd_stall_beat = -1;

    // Fill gaps: valid toggles 1,0,1,0...
    gap_mode = 1'b1;
    issue(32'h0000_0FC0, 2'd0, 1'b0, 18'h0, 32'h300, 34);
    wait_done(1'b1);
    gap_mode = 1'b0;

    // Reset during fill beat 7, with spurious rdata_valid afterwards in IDLE
    issue(32'h8765_4321, 2'd1, 1'b0, 18'h0, 32'h400, 19);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(o_arr_wr_en && o_arr_beat == 4'd7) && n < 100);
    if (!(o_arr_wr_en && o_arr_beat == 4'd7)) fail_event("timeout_beat7");
    rst         = 1'b0;
    spurious_en = 1'b1;
    @(posedge clk);
    #1;
    check("abort_strobes", |{o_arr_rd_en, o_arr_wr_en, o_tag_wr_en, o_mem_req_valid,
                             o_mem_wdata_valid, o_done}, 0);
    check("abort_busy", o_busy, 0);
    check("abort_ready", o_miss_ready, 1);
    arr_q.delete();
    req_q.delete();
    wd_q.delete();
    tag_q.delete();
    lat_q.delete();
    acc_q.delete();
    base_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    spurious_en = 1'b0;
    check("post_reset_ready", o_miss_ready, 1);
    check("post_reset_busy", o_busy, 0);

    // Back-to-back with valid held high; second request presented mid-first-miss
    expect_miss(32'h2222_2080, 2'd0, 1'b0, 18'h0, 32'h500, 19);
    expect_miss(32'h3333_3100, 2'd3, 1'b1, 18'h00F0F, 32'h600, 52);
    drive_req(32'h2222_2080, 2'd0, 1'b0, 18'h0);
    wait_accept();
    drive_req(32'h3333_3100, 2'd3, 1'b1, 18'h00F0F);
    wait_done(1'b0);
    @(negedge clk);
    check("b2b_accept", o_miss_ready && i_miss_valid, 1);
    check("b2b_gap", cyc - last_done_cyc, 1);
    @(posedge clk);
    #1;
    i_miss_valid = 1'b0;
    wait_done(1'b1);
    repeat (3) @(posedge clk);
    #1;

    check("arr_q_empty", arr_q.size(), 0);
    check("req_q_empty", req_q.size(), 0);
    check("wd_q_empty", wd_q.size(), 0);
    check("tag_q_empty", tag_q.size(), 0);
    check("lat_q_empty", lat_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
